// File: rtl/input_debounce_pkg.sv
// Shared types and constants for the input_debounce block.
package input_debounce_pkg;

  // Per-channel debounce FSM: idle/wait for each accepted level.
  typedef enum logic [1:0] {IDLE0, WAIT1, IDLE1, WAIT0} db_state_t;

  localparam int SYNC_STAGES = 2;

  // Counter width for a counter holding 0..n-1; never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-flop sync, polarity fix, 4-state debounce FSM,
// registered level plus one-cycle rise/fall strobes.
// Optional auto-repeat of rise while held: INPUT_DEBOUNCE_AUTOREPEAT_EN.
module debounce_channel
  import input_debounce_pkg::*;
#(
  parameter int   DEBOUNCE_MS = 20,
  parameter logic ACTIVE_LOW  = 1'b0,
  parameter int   HOLD_MS     = 500,
  parameter int   REPEAT_MS   = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int            CW       = cnt_w(DEBOUNCE_MS);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_MS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  db_state_t              state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_d, rise_d, fall_d;

`ifdef INPUT_DEBOUNCE_AUTOREPEAT_EN
  localparam int            HW          = cnt_w(HOLD_MS);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_MS - 1);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_MS - REPEAT_MS);
  logic [HW-1:0] hold_q, hold_d;
`endif

  // Synchroniser; preset to the inactive pin level so release makes no edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= {SYNC_STAGES{ACTIVE_LOW}};
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  assign s = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

  // FSM, tick counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE0;
      cnt_q   <= '0;
      level   <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level   <= level_d;
      rise    <= rise_d;
      fall    <= fall_d;
    end
  end

`ifdef INPUT_DEBOUNCE_AUTOREPEAT_EN
  // Hold counter: ce ticks spent in IDLE1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end
`endif

  // Next state; a revert of s always beats a coincident ce tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
`ifdef INPUT_DEBOUNCE_AUTOREPEAT_EN
    hold_d  = '0;
`endif
    case (state_q)
      IDLE0: if (s) begin
        state_d = WAIT1;
        cnt_d   = '0;
      end
      WAIT1: begin
        if (!s) begin
          state_d = IDLE0;
          cnt_d   = '0;
        end else if (ce) begin
          if (cnt_q == CNT_LAST) begin
            state_d = IDLE1;
            cnt_d   = '0;
            level_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      IDLE1: begin
        if (!s) begin
          state_d = WAIT0;
          cnt_d   = '0;
        end
`ifdef INPUT_DEBOUNCE_AUTOREPEAT_EN
        else begin
          hold_d = hold_q;
          if (ce) begin
            if (hold_q == HOLD_LAST) begin
              rise_d = 1'b1;
              hold_d = HOLD_RELOAD;
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
        end
`endif
      end
      WAIT0: begin
        if (s) begin
          state_d = IDLE1;
          cnt_d   = '0;
        end else if (ce) begin
          if (cnt_q == CNT_LAST) begin
            state_d = IDLE0;
            cnt_d   = '0;
            level_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE0;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/input_debounce.sv
// Multi-channel input conditioner: WIDTH independent debounce channels on a
// shared ce. Optional auto-repeat: INPUT_DEBOUNCE_AUTOREPEAT_EN.
module input_debounce
  import input_debounce_pkg::*;
#(
  parameter int               WIDTH       = 9,
  parameter int               DEBOUNCE_MS = 20,
  parameter logic [WIDTH-1:0] ACTIVE_LOW  = 9'h100,
  parameter int               HOLD_MS     = 500,
  parameter int               REPEAT_MS   = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .ACTIVE_LOW  (ACTIVE_LOW[i]),
      .HOLD_MS     (HOLD_MS),
      .REPEAT_MS   (REPEAT_MS)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .ce    (ce),
      .din   (din[i]),
      .level (level[i]),
      .rise  (rise[i]),
      .fall  (fall[i])
    );
  end

endmodule

// File: tb/tb_input_debounce.sv
// Self-checking bench for input_debounce: directed scenarios plus random
// pin/ce/reset traffic, compared every cycle against a run-length model.
module tb_input_debounce;

  localparam int         W    = 9;
  localparam int         DB   = 20;
  localparam logic [8:0] MASK = 9'h100;
  localparam int         HOLD = 500;
  localparam int         REP  = 100;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ce  = 1'b0;
  logic [W-1:0] din = MASK;
  logic [W-1:0] level, rise, fall;

  input_debounce #(
    .WIDTH(W), .DEBOUNCE_MS(DB), .ACTIVE_LOW(MASK), .HOLD_MS(HOLD), .REPEAT_MS(REP)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce), .din(din),
    .level(level), .rise(rise), .fall(fall)
  );

  initial forever #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pins are seen two edges late; a channel accepts once the
  // synced value has disagreed with level continuously and DB ce ticks have
  // landed after the first disagreeing cycle.
  logic [W-1:0] m_level, m_rise, m_fall, dh1, dh2;
  bit           m_run   [W];
  int           m_ticks [W];
  int           m_hold  [W];

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_level = '0; m_rise = '0; m_fall = '0; dh1 = MASK; dh2 = MASK;
      for (int i = 0; i < W; i++) begin m_run[i] = 0; m_ticks[i] = 0; m_hold[i] = 0; end
    end else begin
      logic [W-1:0] sv;
      sv = dh2 ^ MASK; dh2 = dh1; dh1 = din;
      m_rise = '0; m_fall = '0;
      for (int i = 0; i < W; i++) begin
        if (sv[i] != m_level[i]) begin
          m_hold[i] = 0;
          if (!m_run[i]) begin
            m_run[i] = 1; m_ticks[i] = 0;
          end else if (ce) begin
            m_ticks[i]++;
            if (m_ticks[i] == DB) begin
              m_level[i] = sv[i];
              if (sv[i]) m_rise[i] = 1'b1; else m_fall[i] = 1'b1;
              m_run[i] = 0; m_ticks[i] = 0;
            end
          end
        end else begin
          m_run[i] = 0; m_ticks[i] = 0;
`ifdef INPUT_DEBOUNCE_AUTOREPEAT_EN
          if (m_level[i] && ce) begin
            m_hold[i]++;
            if (m_hold[i] >= HOLD && (m_hold[i] - HOLD) % REP == 0) m_rise[i] = 1'b1;
          end
`endif
        end
      end
    end
  end

  bit chk_en  = 0;
  bit ce_rand = 0;
  int cyc     = 0;
  int rise_cnt [W];
  int fall_cnt [W];

  // Advance n cycles: check at negedge, drive ce just after posedge.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (chk_en) begin
        chk("level", 32'(level), 32'(m_level));
        chk("rise",  32'(rise),  32'(m_rise));
        chk("fall",  32'(fall),  32'(m_fall));
        chk("excl",  32'(rise & fall), 32'd0);
      end
      for (int i = 0; i < W; i++) begin
        rise_cnt[i] += int'(rise[i]);
        fall_cnt[i] += int'(fall[i]);
      end
      @(posedge clk); #2;
      ce = ce_rand ? ($urandom_range(0, 3) == 0) : (cyc % 4 == 0);
      cyc++;
    end
  endtask

  initial begin
    int b0, b1, tot;
    for (int i = 0; i < W; i++) begin rise_cnt[i] = 0; fall_cnt[i] = 0; end
    tick(3);
    chk_en = 1;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_strobe", 32'(rise | fall), 32'd0);
    rst = 1'b0;

    // Quiet inputs for 100 ce: nothing may strobe.
    tick(400);
    tot = 0;
    for (int i = 0; i < W; i++) tot += rise_cnt[i] + fall_cnt[i];
    chk("quiet_strobes", 32'(tot), 32'd0);
    chk("quiet_level", 32'(level), 32'd0);

    // Switch 0 held high.
    b0 = rise_cnt[0];
    din[0] = 1'b1;
    tick(100);
    chk("sw0_rises", 32'(rise_cnt[0] - b0), 32'd1);
    chk("sw0_level", 32'(level), 32'h001);

    // Switch 3 bounce: 5 ce high, 1 clk low, then held.
    b0 = rise_cnt[3];
    din[3] = 1'b1; tick(20);
    din[3] = 1'b0; tick(1);
    din[3] = 1'b1; tick(60);
    chk("bounce_early", 32'(level[3]), 32'd0);
    tick(40);
    chk("bounce_level", 32'(level[3]), 32'd1);
    chk("bounce_rises", 32'(rise_cnt[3] - b0), 32'd1);

    // Active-low button, 30 ms press.
    b0 = rise_cnt[8]; b1 = fall_cnt[8];
    din[8] = 1'b0; tick(120);
    chk("btn_press", 32'(level[8]), 32'd1);
    chk("btn_rises", 32'(rise_cnt[8] - b0), 32'd1);
    din[8] = 1'b1; tick(100);
    chk("btn_release", 32'(level[8]), 32'd0);
    chk("btn_falls", 32'(fall_cnt[8] - b1), 32'd1);

    // Reset about 10 ticks into the wait on switch 2.
    b0 = rise_cnt[2];
    din[2] = 1'b1; tick(43);
    chk("mid_wait_lvl", 32'(level[2]), 32'd0);
    rst = 1'b1; #1;
    chk("rst_mid_level", 32'(level), 32'd0);
    chk("rst_mid_strobe", 32'(rise | fall), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(40);
    chk("fresh_wait", 32'(level[2]), 32'd0);
    chk("abort_rises", 32'(rise_cnt[2] - b0), 32'd0);
    tick(60);
    chk("fresh_accept", 32'(level[2]), 32'd1);
    chk("fresh_rises", 32'(rise_cnt[2] - b0), 32'd1);

    // Long button hold: repeats only when the feature is built in.
    b0 = rise_cnt[8];
    din[8] = 1'b0;
`ifdef INPUT_DEBOUNCE_AUTOREPEAT_EN
    tick(3200);
`else
    tick(800);
`endif
    din[8] = 1'b1; tick(500);
`ifdef INPUT_DEBOUNCE_AUTOREPEAT_EN
    chk("hold_rises", 32'(rise_cnt[8] - b0), 32'd4);
`else
    chk("hold_rises", 32'(rise_cnt[8] - b0), 32'd1);
`endif

    // Random pins, random ce, occasional reset.
    ce_rand = 1;
    for (int it = 0; it < 300; it++) begin
      din[$urandom_range(0, W - 1)] ^= 1'b1;
      tick($urandom_range(1, 60));
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1; tick($urandom_range(1, 3)); rst = 1'b0;
      end
    end
    tick(10);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
